countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
Tick-consuming countdown timer, the receiving end of the one-cycle tick pulse produced by the timer's clock-divider block (ms or s ticks).
- Loads a preset count, decrements once per tick while running, and supports pause/resume.
- Flags expiry with a one-cycle done pulse plus a sticky expired level.
- Sits between the tick generator and the display/control logic of the timer.

Parameters:
WIDTH, 16, width of preset and count value
AUTO_RELOAD, 0, 1 = on expiry reload preset and keep running; 0 = stop in EXPIRED

Ports:
clk  input  1  system clock, all logic on rising edge
rst_b  input  1  asynchronous active-low reset
tick  input  1  time-base pulse from divider; only its rising edge is counted
load  input  1  copy preset into count, go IDLE, clear expired
start  input  1  begin or resume counting
pause  input  1  freeze counting
preset  input  WIDTH  value loaded on load
count  output  WIDTH  current remaining count, registered
running  output  1  high while state is RUN
done  output  1  one-cycle pulse on reaching zero
expired  output  1  sticky, high in EXPIRED until load

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_b).
- Reset values: state IDLE, count 0, tick_d 0, running 0, done 0, expired 0.
- Tick edge: tick_d <= tick every cycle in every state. tick_edge = tick & ~tick_d.
  - A tick held high for N cycles counts once.
  - count changes on the same clock edge that first samples tick high, so it is visible the following cycle.
- States: IDLE, RUN, PAUSE, EXPIRED (2-bit).
- Command priority per cycle: load > start > pause. Lower-priority commands in the same cycle are ignored.
- done defaults to 0 every cycle; it is set only as listed below.
- load (any state): count <= preset; state <= IDLE; expired <= 0; done <= 0. A tick_edge in the same cycle is discarded.
- IDLE:
  - start with count != 0 -> RUN.
  - start with count == 0 -> done=1 for one cycle and state EXPIRED (AUTO_RELOAD=0); with AUTO_RELOAD=1, stay IDLE and assert no done.
  - Ticks are ignored.
- RUN:
  - pause -> PAUSE; a tick_edge in the same cycle is discarded.
  - Otherwise, on tick_edge with count > 1: count <= count-1.
  - On tick_edge with count == 1: count <= 0, done=1 for one cycle, state EXPIRED, expired=1.
  - With AUTO_RELOAD=1 and count == 1: count <= preset, done=1, stay RUN; if preset == 0, go EXPIRED instead.
- PAUSE: ticks ignored, count held; start -> RUN. A tick_edge in the resume cycle is not counted.
- EXPIRED: count 0, expired=1, running=0; start and pause ignored; only load or reset leaves it.
- running = (state == RUN), registered.
- Width: count never wraps below 0; decrement occurs only when count >= 1.
- Reset mid-operation: immediate return to reset values regardless of state.

Decomposition:
- Package timer_pkg: state encodings (IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, EXPIRED=2'b11) and a default timer width constant, shared with the display/control blocks.
- One sub-module: tick_edge_detect (clk, rst_b, in, rise). Holds tick_d; reusable for the button inputs.
- FSM and counter stay in countdown_timer.

Test Plan:
- Reset, then preset=3, load, start, three 1-cycle ticks spaced 10 cycles apart -> count 3,2,1,0 after each tick. done high exactly one cycle after the third tick. expired=1, running=0.
- preset=5, run, hold tick high 20 cycles -> count 4 only (single decrement).
- preset=4, run, one tick (count 3), pause, two ticks, start, one tick -> count stays 3 through pause and ends at 2.
- preset=2, AUTO_RELOAD=1, run, four ticks -> count 1,2,1,2. done pulses after ticks 2 and 4; running stays 1.
- In EXPIRED, start asserted -> no change. load with preset=7 -> count 7, expired 0, state IDLE.
- rst_b low mid-RUN at count 9 -> count 0, running 0, done 0, expired 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer blocks: state encodings and default width.
package timer_pkg;

    localparam int TIMER_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_EXPIRED = 2'b11
    } timer_state_e;

endpackage

// File: rtl/countdown_timer_tick_edge_detect.sv
// Rising-edge detector: one-cycle rise output for each low-to-high transition
// of a level input. Reused for tick and button inputs.
module tick_edge_detect (
    input  logic clk,
    input  logic rst_b,
    input  logic in,
    output logic rise
);

    logic in_d;

    // Delayed copy of the input, updated every cycle regardless of consumer state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            in_d <= 1'b0;
        end else begin
            in_d <= in;
        end
    end

    assign rise = in & ~in_d;

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer driven by the divider's tick pulse. Loads a preset, counts
// down one per tick rising edge while running, supports pause/resume and
// flags expiry with a done pulse and a sticky expired level.
//
// Commands (load, start, pause) are plain level inputs sampled every cycle;
// there is no handshake. Priority within a cycle is load > start > pause.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH       = TIMER_WIDTH,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             tick,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired,
    output logic [1:0]       state_dbg
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    timer_state_e     state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             done_nxt;
    logic             expired_nxt;
    logic             tick_edge;

    tick_edge_detect u_tick_edge (
        .clk   (clk),
        .rst_b (rst_b),
        .in    (tick),
        .rise  (tick_edge)
    );

    // State and registered outputs; running follows the next state so it is
    // high exactly while state is RUN.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= ST_IDLE;
            count   <= ZERO;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            running <= (state_nxt == ST_RUN);
            done    <= done_nxt;
            expired <= expired_nxt;
        end
    end

    // Next-state, next-count and flag logic with load taking precedence.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        done_nxt    = 1'b0;
        expired_nxt = expired;

        if (load) begin
            // A tick edge in a load cycle is deliberately dropped.
            count_nxt   = preset;
            state_nxt   = ST_IDLE;
            expired_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (count != ZERO) begin
                            state_nxt = ST_RUN;
                        end else if (AUTO_RELOAD == 0) begin
                            done_nxt    = 1'b1;
                            state_nxt   = ST_EXPIRED;
                            expired_nxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause && !start) begin
                        // Pausing discards a coincident tick edge.
                        state_nxt = ST_PAUSE;
                    end else if (tick_edge) begin
                        if (count > ONE) begin
                            count_nxt = count - ONE;
                        end else if (count == ONE) begin
                            done_nxt = 1'b1;
                            if ((AUTO_RELOAD != 0) && (preset != ZERO)) begin
                                count_nxt = preset;
                            end else begin
                                count_nxt   = ZERO;
                                state_nxt   = ST_EXPIRED;
                                expired_nxt = 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    // Resume cycle does not count a coincident tick edge.
                    if (start) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    count_nxt   = ZERO;
                    expired_nxt = 1'b1;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance without auto-reload and
// one with auto-reload, sharing all inputs.
module tb_countdown_timer;
    import timer_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst_b;
    logic         tick;
    logic         load;
    logic         start;
    logic         pause;
    logic [W-1:0] preset;

    logic [W-1:0] count0, count1;
    logic         running0, running1;
    logic         done0, done1;
    logic         expired0, expired1;
    logic [1:0]   state0, state1;

    int total = 0;
    int bad   = 0;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W), .AUTO_RELOAD(0)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .tick      (tick),
        .load      (load),
        .start     (start),
        .pause     (pause),
        .preset    (preset),
        .count     (count0),
        .running   (running0),
        .done      (done0),
        .expired   (expired0),
        .state_dbg (state0)
    );

    countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1)) dut_ar (
        .clk       (clk),
        .rst_b     (rst_b),
        .tick      (tick),
        .load      (load),
        .start     (start),
        .pause     (pause),
        .preset    (preset),
        .count     (count1),
        .running   (running1),
        .done      (done1),
        .expired   (expired1),
        .state_dbg (state1)
    );

    // Driver tasks
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load(input logic [W-1:0] val);
        preset = val;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_b  = 1'b1;
        tick   = 1'b0;
        load   = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        preset = '0;
        #2 rst_b = 1'b0;
        step(2);
        chk("rst_count",   count0,   0);
        chk("rst_running", running0, 0);
        chk("rst_done",    done0,    0);
        chk("rst_expired", expired0, 0);
        chk("rst_state",   state0,   ST_IDLE);
        rst_b = 1'b1;
        step(1);

        // Basic countdown from 3
        pulse_load(16'd3);
        chk("ld3_count", count0, 3);
        chk("ld3_state", state0, ST_IDLE);
        pulse_start();
        chk("st_running", running0, 1);
        chk("st_state",   state0,   ST_RUN);
        step(9);
        pulse_tick();
        chk("t1_count", count0, 2);
        chk("t1_done",  done0,  0);
        step(9);
        pulse_tick();
        chk("t2_count", count0, 1);
        step(9);
        pulse_tick();
        chk("t3_count",   count0,   0);
        chk("t3_done",    done0,    1);
        chk("t3_expired", expired0, 1);
        chk("t3_running", running0, 0);
        chk("t3_state",   state0,   ST_EXPIRED);
        step(1);
        chk("t3_done_drop", done0,    0);
        chk("t3_exp_hold",  expired0, 1);

        // EXPIRED ignores start and pause; load leaves it
        pulse_start();
        chk("exp_start_state", state0, ST_EXPIRED);
        chk("exp_start_count", count0, 0);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        chk("exp_pause_state", state0, ST_EXPIRED);
        pulse_load(16'd7);
        chk("ld7_count",   count0,   7);
        chk("ld7_expired", expired0, 0);
        chk("ld7_state",   state0,   ST_IDLE);

        // Ticks ignored in IDLE
        step(2);
        pulse_tick();
        chk("idle_tick_count", count0, 7);

        // Held tick counts once
        pulse_load(16'd5);
        pulse_start();
        tick = 1'b1;
        step(1);
        chk("hold_first", count0, 4);
        step(19);
        tick = 1'b0;
        step(1);
        chk("hold_end", count0, 4);

        // Pause / resume, including coincident tick edges
        pulse_load(16'd4);
        pulse_start();
        pulse_tick();
        chk("p_t1_count", count0, 3);
        step(2);
        pause = 1'b1;
        tick  = 1'b1;
        step(1);
        pause = 1'b0;
        tick  = 1'b0;
        chk("p_enter_count",   count0,   3);
        chk("p_enter_state",   state0,   ST_PAUSE);
        chk("p_enter_running", running0, 0);
        step(2);
        pulse_tick();
        step(2);
        pulse_tick();
        chk("p_ticks_count", count0, 3);
        step(2);
        start = 1'b1;
        tick  = 1'b1;
        step(1);
        start = 1'b0;
        tick  = 1'b0;
        chk("p_resume_count", count0,   3);
        chk("p_resume_run",   running0, 1);
        step(2);
        pulse_tick();
        chk("p_final_count", count0, 2);

        // Load in the same cycle as a tick edge discards the tick
        step(2);
        preset = 16'd6;
        load   = 1'b1;
        tick   = 1'b1;
        step(1);
        load   = 1'b0;
        tick   = 1'b0;
        chk("ld_tick_count", count0, 6);
        chk("ld_tick_state", state0, ST_IDLE);

        // Start with zero count
        pulse_load(16'd0);
        pulse_start();
        chk("z_done0",    done0,  1);
        chk("z_state0",   state0, ST_EXPIRED);
        chk("z_done_ar",  done1,  0);
        chk("z_state_ar", state1, ST_IDLE);

        // Auto-reload from 2
        pulse_load(16'd2);
        pulse_start();
        step(2);
        pulse_tick();
        chk("ar_t1_count", count1, 1);
        chk("ar_t1_done",  done1,  0);
        step(2);
        pulse_tick();
        chk("ar_t2_count",   count1,   2);
        chk("ar_t2_done",    done1,    1);
        chk("ar_t2_running", running1, 1);
        chk("ar_t2_expired", expired1, 0);
        step(1);
        chk("ar_t2_drop", done1, 0);
        step(1);
        pulse_tick();
        chk("ar_t3_count", count1, 1);
        step(2);
        pulse_tick();
        chk("ar_t4_count",   count1,   2);
        chk("ar_t4_done",    done1,    1);
        chk("ar_t4_running", running1, 1);

        // Asynchronous reset mid-run at count 9
        pulse_load(16'd9);
        pulse_start();
        chk("pre_rst_count", count0, 9);
        #3 rst_b = 1'b0;
        #1;
        chk("arst_count",   count0,   0);
        chk("arst_running", running0, 0);
        chk("arst_done",    done0,    0);
        chk("arst_expired", expired0, 0);
        chk("arst_state",   state0,   ST_IDLE);
        step(1);
        rst_b = 1'b1;
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
